piece_queue: RTL and testbench

Consumer side of the piece-index generator. It pulls 3-bit piece indices from the generator by pulsing its update input, and discards out-of-range codes. Valid pieces go into a DEPTH-entry preview queue. On request, the queue hands the head piece to the board/spawn logic, and it exposes the upcoming pieces for the "next" display.

---
 rtl/tetris_pkg.sv | 31 +++
 rtl/piece_shift_fifo.sv | 82 ++++++++
 rtl/piece_queue.sv | 122 ++++++++++++
 tb/tb_piece_queue.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared definitions for the piece pipeline.
// Contents:
//   IDX_W          piece index width (fixed by the generator interface)
//   PIECE_*        piece codes 0..6, PIECE_INVALID = 7
//   queue_state_e  piece_queue FSM states
//   piece_valid()  true for codes the queue accepts
package tetris_pkg;

  localparam int IDX_W = 3;

  localparam logic [IDX_W-1:0] PIECE_I       = 3'd0;
  localparam logic [IDX_W-1:0] PIECE_J       = 3'd1;
  localparam logic [IDX_W-1:0] PIECE_L       = 3'd2;
  localparam logic [IDX_W-1:0] PIECE_O       = 3'd3;
  localparam logic [IDX_W-1:0] PIECE_S       = 3'd4;
  localparam logic [IDX_W-1:0] PIECE_T       = 3'd5;
  localparam logic [IDX_W-1:0] PIECE_Z       = 3'd6;
  localparam logic [IDX_W-1:0] PIECE_INVALID = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } queue_state_e;

  function automatic logic piece_valid(input logic [IDX_W-1:0] idx);
    return idx <= PIECE_Z;
  endfunction

endpackage

// File: rtl/piece_shift_fifo.sv
// Shift-toward-head FIFO: slot 0 is always the oldest entry, so the head and
// the preview slots are plain register reads.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   flush_i      clears all entries and the count (wins over push/pop)
//   push_i       write data_i at the tail (caller guarantees not full,
//                unless pop_i is also high)
//   pop_i        drop the head, shift remaining entries toward slot 0
//   data_i       entry to push
//   head_o       slot 0
//   count_o      number of valid entries
//   preview_o    flat slot array, slot k at [k*W +: W]; unused slots read 0
module piece_shift_fifo #(
  parameter int DEPTH = 3,
  parameter int W     = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               data_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [DEPTH*W-1:0]         preview_o
);

  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] tail;

  // On a simultaneous pop the tail has already moved down one slot.
  assign tail = pop_i ? cnt_q - CW'(1) : cnt_q;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) mem_d[k] = mem_q[k];
    cnt_d = cnt_q;
    if (flush_i) begin
      for (int k = 0; k < DEPTH; k++) mem_d[k] = '0;
      cnt_d = '0;
    end else begin
      if (pop_i) begin
        for (int k = 0; k < DEPTH-1; k++) mem_d[k] = mem_q[k+1];
        mem_d[DEPTH-1] = '0;
      end
      if (push_i) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (CW'(k) == tail) mem_d[k] = data_i;
        end
      end
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= mem_d[k];
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = mem_q[0];
  assign count_o = cnt_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_preview
    assign preview_o[g*W +: W] = mem_q[g];
  end

  // Overflow and underflow cannot occur with a well-behaved caller.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(!flush_i && push_i && !pop_i && cnt_q == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(!flush_i && pop_i && cnt_q == '0));

endmodule

// File: rtl/piece_queue.sv
// Consumer side of the piece-index generator. Fetches one index per cycle
// while the queue has room, drops the invalid code, and hands the head piece
// to the board on request.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   start         new-game pulse: flush and refill (highest priority)
//   gameover      level: freeze queue and generator (enters HALT)
//   gen_index     current generator value
//   gen_update    advance strobe to the generator (combinational)
//   spawn_req     one-cycle request for the next piece
//   spawn_ack     registered one-cycle pulse, spawn_piece valid with it
//   spawn_piece   delivered piece, held between acks
//   preview       queue slots, slot 0 = head
//   count         valid entries
//   ready         high in RUN
//   dbg_state     current FSM state
// Handshake: spawn_req is a request pulse that is remembered (pending) until
// served; a request is served on the clock edge where the state is RUN, the
// queue is non-empty and nothing freezes the queue; spawn_ack/spawn_piece
// appear in the cycle after that edge. Extra requests while one is pending
// merge into it.
module piece_queue
  import tetris_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       gameover,
  input  logic [IDX_W-1:0]           gen_index,
  output logic                       gen_update,
  input  logic                       spawn_req,
  output logic                       spawn_ack,
  output logic [IDX_W-1:0]           spawn_piece,
  output logic [DEPTH*IDX_W-1:0]     preview,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ready,
  output logic [1:0]                 dbg_state
);

  localparam int CW = $clog2(DEPTH+1);

  queue_state_e   state_q, state_d;
  logic           pending_q, pending_d;
  logic           ack_q, ack_d;
  logic [IDX_W-1:0] piece_q, piece_d;

  logic           active;
  logic           fetch;
  logic           push;
  logic           pop;
  logic           want;
  logic [IDX_W-1:0] head;
  logic [CW-1:0]  cnt;

  piece_shift_fifo #(.DEPTH(DEPTH), .W(IDX_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (start),
    .push_i    (push),
    .pop_i     (pop),
    .data_i    (gen_index),
    .head_o    (head),
    .count_o   (cnt),
    .preview_o (preview)
  );

  // Queue may move only in FILL/RUN, and never in a start or gameover cycle.
  assign active = (state_q == FILL || state_q == RUN) && !start && !gameover;
  // Room is judged on the pre-edge count, so a full queue never pushes even
  // when it pops in the same cycle.
  assign fetch  = active && (cnt < CW'(DEPTH));
  assign push   = fetch && piece_valid(gen_index);
  // A fresh request is served in the same cycle it arrives, giving a
  // one-cycle request-to-ack latency on a non-empty queue.
  assign want   = pending_q || spawn_req;
  assign pop    = active && (state_q == RUN) && want && (cnt != '0);

  always_comb begin
    state_d   = state_q;
    pending_d = active && want && !pop;
    ack_d     = pop;
    piece_d   = pop ? head : piece_q;
    if (start) begin
      state_d = FILL;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        FILL: begin
          if (gameover) state_d = HALT;
          else if (push && cnt == CW'(DEPTH-1)) state_d = RUN;
        end
        RUN:  if (gameover) state_d = HALT;
        HALT: state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      piece_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      piece_q   <= piece_d;
    end
  end

  assign gen_update  = fetch;
  assign spawn_ack   = ack_q;
  assign spawn_piece = piece_q;
  assign count       = cnt;
  assign ready       = (state_q == RUN);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_piece_queue.sv
module tb_piece_queue;

  localparam int DEPTH = 3;
  localparam int W     = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           start = 1'b0;
  logic           gameover = 1'b0;
  logic [W-1:0]   gen_index = '0;
  logic           gen_update;
  logic           spawn_req = 1'b0;
  logic           spawn_ack;
  logic [W-1:0]   spawn_piece;
  logic [DEPTH*W-1:0] preview;
  logic [1:0]     count;
  logic           ready;
  logic [1:0]     dbg_state;

  piece_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .gameover    (gameover),
    .gen_index   (gen_index),
    .gen_update  (gen_update),
    .spawn_req   (spawn_req),
    .spawn_ack   (spawn_ack),
    .spawn_piece (spawn_piece),
    .preview     (preview),
    .count       (count),
    .ready       (ready),
    .dbg_state   (dbg_state)
  );

  localparam logic [1:0] S_IDLE = 2'd0, S_FILL = 2'd1, S_RUN = 2'd2, S_HALT = 2'd3;

  // ---------------- vector table ----------------
  typedef struct {
    logic       st, go, rq;
    logic [2:0] gi;
    logic       gu, ack;
    logic [2:0] pc;
    logic [1:0] cnt;
    logic       rdy;
    logic [8:0] pv;
    logic [1:0] state;
  } vec_t;

  vec_t vecs[$];
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic st, input logic go, input logic rq, input logic [2:0] gi,
                     input logic gu, input logic ack, input logic [2:0] pc, input logic [1:0] cnt,
                     input logic rdy, input logic [8:0] pv, input logic [1:0] state);
    vec_t v;
    v.st = st; v.go = go; v.rq = rq; v.gi = gi;
    v.gu = gu; v.ack = ack; v.pc = pc; v.cnt = cnt; v.rdy = rdy; v.pv = pv; v.state = state;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every ack must deliver the next expected piece.
  task automatic sb_check(input string tag);
    logic [W-1:0] e;
    if (spawn_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s unexpected_ack: got piece %0d expected no ack", tag, spawn_piece);
      end else begin
        e = exp_q.pop_front();
        chk({tag, " sb_piece"}, 16'(spawn_piece), 16'(e));
      end
    end
  endtask

  task automatic drive(input logic st, input logic go, input logic rq, input logic [2:0] gi);
    start = st; gameover = go; spawn_req = rq; gen_index = gi;
  endtask

  initial begin
    // st go rq gi | gu ack pc cnt rdy preview state
    add(0,0,1,0, 0,0,0,0,0, 9'h000, S_IDLE);  // IDLE ignores request
    add(1,0,0,0, 0,0,0,0,0, 9'h000, S_IDLE);  // start cycle: no fetch
    add(0,0,0,0, 1,0,0,0,0, 9'h000, S_FILL);
    add(0,0,0,1, 1,0,0,1,0, 9'h000, S_FILL);
    add(0,0,0,2, 1,0,0,2,0, 9'h008, S_FILL);
    add(0,0,0,3, 0,0,0,3,1, 9'h088, S_RUN);   // full: {2,1,0}
    add(0,0,1,3, 0,0,0,3,1, 9'h088, S_RUN);   // request
    add(0,0,0,3, 1,1,0,2,1, 9'h011, S_RUN);   // ack piece 0, refill 3
    add(0,0,0,4, 0,0,0,3,1, 9'h0D1, S_RUN);   // {3,2,1}
    add(0,0,1,4, 0,0,0,3,1, 9'h0D1, S_RUN);   // back-to-back requests
    add(0,0,1,4, 1,1,1,2,1, 9'h01A, S_RUN);
    add(0,0,1,5, 1,1,2,2,1, 9'h023, S_RUN);
    add(0,0,0,6, 1,1,3,2,1, 9'h02C, S_RUN);
    add(0,0,0,7, 0,0,3,3,1, 9'h1AC, S_RUN);   // {6,5,4}
    add(0,0,1,7, 0,0,3,3,1, 9'h1AC, S_RUN);   // drain with invalid codes
    add(0,0,1,7, 1,1,4,2,1, 9'h035, S_RUN);
    add(0,0,1,7, 1,1,5,1,1, 9'h006, S_RUN);
    add(0,0,1,7, 1,1,6,0,1, 9'h000, S_RUN);   // empty, request pends
    add(0,0,0,7, 1,0,6,0,1, 9'h000, S_RUN);
    add(0,0,1,1, 1,0,6,0,1, 9'h000, S_RUN);   // extra request absorbed, push 1
    add(0,0,0,2, 1,0,6,1,1, 9'h001, S_RUN);   // pending served now
    add(0,0,0,3, 1,1,1,1,1, 9'h002, S_RUN);
    add(0,0,0,4, 1,0,1,2,1, 9'h01A, S_RUN);   // single ack only
    add(0,0,0,5, 0,0,1,3,1, 9'h11A, S_RUN);
    add(0,1,1,5, 0,0,1,3,1, 9'h11A, S_RUN);   // gameover in RUN
    add(0,0,1,5, 0,0,1,3,0, 9'h11A, S_HALT);
    add(1,0,0,5, 0,0,1,3,0, 9'h11A, S_HALT);  // restart
    add(0,0,0,5, 1,0,1,0,0, 9'h000, S_FILL);
    add(0,1,1,6, 0,0,1,1,0, 9'h005, S_FILL);  // gameover mid-fill
    for (int i = 0; i < 10; i++) add(0,1,1,6, 0,0,1,1,0, 9'h005, S_HALT);
    add(1,1,0,6, 0,0,1,1,0, 9'h005, S_HALT);  // start with gameover high
    add(0,0,0,5, 1,0,1,0,0, 9'h000, S_FILL);  // fill 5,6,7,0
    add(0,0,0,6, 1,0,1,1,0, 9'h005, S_FILL);
    add(0,0,0,7, 1,0,1,2,0, 9'h035, S_FILL);  // 7 skipped, strobe still pulses
    add(0,0,0,0, 1,0,1,2,0, 9'h035, S_FILL);
    add(0,0,1,1, 0,0,1,3,1, 9'h035, S_RUN);   // {0,6,5}, request

    exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1, 3'd5};

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      string t;
      @(negedge clk);
      drive(vecs[i].st, vecs[i].go, vecs[i].rq, vecs[i].gi);
      #1;
      t = $sformatf("v%0d", i);
      chk({t, " gen_update"}, 16'(gen_update), 16'(vecs[i].gu));
      chk({t, " spawn_ack"}, 16'(spawn_ack), 16'(vecs[i].ack));
      chk({t, " spawn_piece"}, 16'(spawn_piece), 16'(vecs[i].pc));
      chk({t, " count"}, 16'(count), 16'(vecs[i].cnt));
      chk({t, " ready"}, 16'(ready), 16'(vecs[i].rdy));
      chk({t, " preview"}, 16'(preview), 16'(vecs[i].pv));
      chk({t, " state"}, 16'(dbg_state), 16'(vecs[i].state));
      sb_check(t);
    end

    // Ack of piece 5 visible, then asynchronous reset mid-cycle.
    @(negedge clk);
    drive(0, 0, 0, 3'd1);
    #1;
    chk("pre_rst ack", 16'(spawn_ack), 16'd1);
    chk("pre_rst count", 16'(count), 16'd2);
    chk("pre_rst gen_update", 16'(gen_update), 16'd1);
    sb_check("pre_rst");
    #1 rst_n = 1'b0;
    #1;
    chk("rst gen_update", 16'(gen_update), 16'd0);
    chk("rst spawn_ack", 16'(spawn_ack), 16'd0);
    chk("rst spawn_piece", 16'(spawn_piece), 16'd0);
    chk("rst count", 16'(count), 16'd0);
    chk("rst ready", 16'(ready), 16'd0);
    chk("rst preview", 16'(preview), 16'd0);
    chk("rst state", 16'(dbg_state), 16'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(0, 0, 1, 3'd3);
      #1;
      chk($sformatf("post_rst%0d gen_update", i), 16'(gen_update), 16'd0);
      chk($sformatf("post_rst%0d state", i), 16'(dbg_state), 16'(S_IDLE));
    end
    @(negedge clk);
    drive(1, 0, 0, 3'd3);
    #1 chk("restart start_cycle gen_update", 16'(gen_update), 16'd0);
    @(negedge clk);
    drive(0, 0, 0, 3'd3);
    #1;
    chk("restart gen_update", 16'(gen_update), 16'd1);
    chk("restart state", 16'(dbg_state), 16'(S_FILL));
    chk("restart ack", 16'(spawn_ack), 16'd0);

    chk("sb_remaining", 16'(exp_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
